// File: rtl/fizzbuzz_pkg.sv
// Shared types and default widths for the FizzBuzz scheduler.
// Imported by the scheduler top and its modulo counter.
package fizzbuzz_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int DIV_W_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [DIV_W_DEF-1:0] fizz;
        logic [DIV_W_DEF-1:0] buzz;
        logic [CNT_W_DEF-1:0] len;
    } cmd_t;

endpackage

// File: rtl/fizzbuzz_mod_counter.sv
// Wrapping remainder counter: tracks value mod divisor without a divider.
// Cleared at run start, stepped once per accepted non-last beat.
module fizzbuzz_mod_counter
    import fizzbuzz_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] rem,
    output logic             is_zero
);

    logic [DIV_W-1:0] rem_q;
    logic [DIV_W-1:0] rem_d;

    always_comb begin
        rem_d = rem_q;
        if (clear) begin
            rem_d = '0;
        end else if (advance) begin
            rem_d = (rem_q == divisor - 1'b1) ? '0 : rem_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem     = rem_q;
    assign is_zero = (rem_q == '0);

endmodule

// File: rtl/fizzbuzz_scheduler.sv
// Command-driven FizzBuzz sequencer: one run per accepted command,
// one classified beat per value on a backpressured output stream.
module fizzbuzz_scheduler
    import fizzbuzz_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DIV_W-1:0] cmd_fizz,
    input  logic [DIV_W-1:0] cmd_buzz,
    input  logic [CNT_W-1:0] cmd_len,
    output logic             cmd_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_value,
    output logic             out_fizz,
    output logic             out_buzz,
    output logic             out_fizzbuzz,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic [DIV_W-1:0] fizz_q;
    logic [DIV_W-1:0] buzz_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] value_q;
    logic             err_q;
    logic             done_q;

    logic cmd_acc;
    logic cmd_bad;
    logic start;
    logic beat;
    logic is_last;
    logic step;
    logic f_zero;
    logic b_zero;
    logic [DIV_W-1:0] unused_rem_f;
    logic [DIV_W-1:0] unused_rem_b;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = busy;

    assign cmd_acc = cmd_valid && cmd_ready;
    assign cmd_bad = (cmd_fizz == '0) || (cmd_buzz == '0) || (cmd_len == '0);
    assign start   = cmd_acc && !cmd_bad;
    assign beat    = out_valid && out_ready;
    assign is_last = (value_q == len_q - 1'b1);
    assign step    = beat && !is_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            fizz_q  <= '0;
            buzz_q  <= '0;
            len_q   <= '0;
            value_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            err_q  <= cmd_acc && cmd_bad;
            done_q <= beat && is_last;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        fizz_q  <= cmd_fizz;
                        buzz_q  <= cmd_buzz;
                        len_q   <= cmd_len;
                        value_q <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (beat) begin
                        if (is_last) begin
                            state_q <= IDLE;
                        end else begin
                            value_q <= value_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fizzbuzz_mod_counter #(.DIV_W(DIV_W)) u_fizz (
        .clk     (clk),
        .reset   (reset),
        .clear   (start),
        .advance (step),
        .divisor (fizz_q),
        .rem     (unused_rem_f),
        .is_zero (f_zero)
    );

    fizzbuzz_mod_counter #(.DIV_W(DIV_W)) u_buzz (
        .clk     (clk),
        .reset   (reset),
        .clear   (start),
        .advance (step),
        .divisor (buzz_q),
        .rem     (unused_rem_b),
        .is_zero (b_zero)
    );

    // Flags are gated so nothing leaks out between runs.
    assign out_value    = out_valid ? value_q : '0;
    assign out_fizz     = out_valid && f_zero;
    assign out_buzz     = out_valid && b_zero;
    assign out_fizzbuzz = out_valid && f_zero && b_zero;
    assign out_last     = out_valid && is_last;
    assign cmd_err      = err_q;
    assign done         = done_q;

endmodule

// File: tb/tb_fizzbuzz_scheduler.sv
// Directed scoreboard bench for fizzbuzz_scheduler.
// Expected beats are queued at command time and popped on each handshake.
module tb_fizzbuzz_scheduler;
    import fizzbuzz_pkg::*;

    typedef struct {
        int value;
        int f;
        int b;
        int fb;
        int last;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_fizz;
    logic [3:0] cmd_buzz;
    logic [7:0] cmd_len;
    logic       cmd_err;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_value;
    logic       out_fizz;
    logic       out_buzz;
    logic       out_fizzbuzz;
    logic       out_last;
    logic       busy;
    logic       done;

    int    vectors = 0;
    int    miscompares = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    fizzbuzz_scheduler #(.CNT_W(8), .DIV_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_fizz     (cmd_fizz),
        .cmd_buzz     (cmd_buzz),
        .cmd_len      (cmd_len),
        .cmd_err      (cmd_err),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_value    (out_value),
        .out_fizz     (out_fizz),
        .out_buzz     (out_buzz),
        .out_fizzbuzz (out_fizzbuzz),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input int obs, input int exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic start_cmd(input int f, input int b, input int l);
        cmd_t c;
        c.fizz = 4'(f);
        c.buzz = 4'(b);
        c.len  = 8'(l);
        chk("cmd_ready_pre", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_fizz  = c.fizz;
        cmd_buzz  = c.buzz;
        cmd_len   = c.len;
        for (int v = 0; v < l; v++) begin
            beat_t e;
            e.value = v;
            e.f     = ((v % f) == 0) ? 1 : 0;
            e.b     = ((v % b) == 0) ? 1 : 0;
            e.fb    = e.f & e.b;
            e.last  = (v == l - 1) ? 1 : 0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("first_beat_valid", int'(out_valid), 1);
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0,1
    task automatic drain(input int mode, output int fb_cnt, output int last_v);
        int    k = 0;
        bit    fin = 0;
        bit    stall_prev = 0;
        beat_t snap;
        beat_t e;
        fb_cnt = 0;
        last_v = -1;
        while (!fin && k < 2000) begin
            out_ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            chk("run_valid", int'(out_valid), 1);
            chk("run_done_low", int'(done), 0);
            if (stall_prev) begin
                chk("hold_value", int'(out_value), snap.value);
                chk("hold_fizz", int'(out_fizz), snap.f);
                chk("hold_buzz", int'(out_buzz), snap.b);
                chk("hold_last", int'(out_last), snap.last);
            end
            if (out_ready) begin
                chk("sb_nonempty", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("beat_value", int'(out_value), e.value);
                    chk("beat_fizz", int'(out_fizz), e.f);
                    chk("beat_buzz", int'(out_buzz), e.b);
                    chk("beat_fizzbuzz", int'(out_fizzbuzz), e.fb);
                    chk("beat_last", int'(out_last), e.last);
                    if (out_fizzbuzz) fb_cnt++;
                    last_v = int'(out_value);
                    if (e.last != 0) fin = 1;
                end
                stall_prev = 0;
            end else begin
                stall_prev = 1;
                snap.value = int'(out_value);
                snap.f     = int'(out_fizz);
                snap.b     = int'(out_buzz);
                snap.last  = int'(out_last);
            end
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", int'(fin), 1);
        chk("done_pulse", int'(done), 1);
        chk("done_idle_busy", int'(busy), 0);
        chk("done_cmd_ready", int'(cmd_ready), 1);
        chk("done_out_valid", int'(out_valid), 0);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        int fb;
        int lv;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_fizz  = '0;
        cmd_buzz  = '0;
        cmd_len   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_value", int'(out_value), 0);
        chk("rst_flags", int'({out_fizz, out_buzz, out_fizzbuzz, out_last}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cmd_err", int'(cmd_err), 0);
        reset = 1'b0;
        @(negedge clk);

        start_cmd(3, 5, 16);
        drain(0, fb, lv);
        chk("run16_fb_count", fb, 2);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);

        start_cmd(3, 5, 16);
        drain(1, fb, lv);
        chk("bp_last_value", lv, 15);
        @(negedge clk);

        cmd_valid = 1'b1;
        cmd_fizz  = 4'd0;
        cmd_buzz  = 4'd5;
        cmd_len   = 8'd16;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("err_fizz0", int'(cmd_err), 1);
        chk("err_fizz0_ready", int'(cmd_ready), 1);
        chk("err_fizz0_valid", int'(out_valid), 0);
        @(negedge clk);
        chk("err_fizz0_pulse", int'(cmd_err), 0);
        chk("err_fizz0_valid2", int'(out_valid), 0);

        cmd_valid = 1'b1;
        cmd_fizz  = 4'd3;
        cmd_buzz  = 4'd5;
        cmd_len   = 8'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("err_len0", int'(cmd_err), 1);
        chk("err_len0_ready", int'(cmd_ready), 1);
        chk("err_len0_valid", int'(out_valid), 0);
        @(negedge clk);
        chk("err_len0_pulse", int'(cmd_err), 0);
        chk("err_len0_valid2", int'(out_valid), 0);

        start_cmd(1, 2, 1);
        drain(0, fb, lv);
        chk("len1_fb", fb, 1);
        start_cmd(3, 5, 16);
        drain(0, fb, lv);
        @(negedge clk);

        start_cmd(15, 7, 255);
        drain(0, fb, lv);
        chk("len255_fb_count", fb, 3);
        chk("len255_last_value", lv, 254);
        @(negedge clk);

        start_cmd(3, 5, 10);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat_t e;
            e = exp_q.pop_front();
            chk("pre_rst_value", int'(out_value), e.value);
            @(negedge clk);
        end
        chk("beat4_value", int'(out_value), 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(cmd_ready), 1);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        chk("abort_done2", int'(done), 0);
        chk("abort_valid2", int'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
